// File: rtl/subseq_frame_tx_pkg.sv
// Shared definitions for the subsequence-sum frame transmitter and its engine.
//   ENG_FRAME_LEN : samples per frame the engine expects
//   ENG_DW        : signed sample width
//   ENG_SW        : sum/result width
//   tx_state_e    : transmitter FSM states
package subseq_frame_tx_pkg;

  localparam int ENG_FRAME_LEN = 8;
  localparam int ENG_DW        = 8;
  localparam int ENG_SW        = 12;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GAP  = 3'd1,
    SEND = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } tx_state_e;

endpackage

// File: rtl/subseq_frame_tx_if.sv
// Sample/result link between the frame transmitter and the subsequence-sum engine.
//   s_valid     : sample valid (transmitter -> engine)
//   s_data      : signed sample (transmitter -> engine)
//   s_valid_out : level-held result valid (engine -> transmitter)
//   s_max_sum   : maximum subsequence sum (engine -> transmitter)
interface subseq_frame_tx_if
  import subseq_frame_tx_pkg::*;
#(
  parameter int DW = ENG_DW,
  parameter int SW = ENG_SW
) ();

  logic                 s_valid;
  logic signed [DW-1:0] s_data;
  logic                 s_valid_out;
  logic [SW-1:0]        s_max_sum;

  modport master (output s_valid, output s_data, input s_valid_out, input s_max_sum);
  modport slave  (input s_valid, input s_data, output s_valid_out, output s_max_sum);

endinterface

// File: rtl/subseq_ref_acc.sv
// Kadane reference accumulator: running partial sum clamped at zero and the
// largest partial sum seen since the last clear.
//   clk, rst : clock, async active-high reset
//   clr      : restart both sums at 0 (wins over en)
//   en       : accumulate din this cycle
//   din      : signed sample
//   max_out  : largest non-negative subsequence sum so far
module subseq_ref_acc
  import subseq_frame_tx_pkg::*;
#(
  parameter int DW = ENG_DW,
  parameter int SW = ENG_SW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] din,
  output logic [SW-1:0]        max_out
);

  logic signed [SW-1:0] par;
  logic signed [SW-1:0] best;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] par_next;

  assign sum      = par + {{(SW-DW){din[DW-1]}}, din};
  assign par_next = sum[SW-1] ? '0 : sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par  <= '0;
      best <= '0;
    end else if (clr) begin
      par  <= '0;
      best <= '0;
    end else if (en) begin
      par <= par_next;
      if (par_next > best) best <= par_next;
    end
  end

  assign max_out = best;

endmodule

// File: rtl/subseq_frame_tx.sv
// Frame transmitter: buffers FRAME_LEN host samples, streams them to the
// engine as one unbroken valid burst, then waits for the engine's result
// (or a timeout) and hands it back to the host.
// Optional reference checker enabled by defining SUBSEQ_TX_CHECK_EN.
//   clk, rst        : clock, async active-high reset
//   wr_en/addr/data : host buffer write (IDLE only)
//   start           : request to send the buffered frame (IDLE only)
//   busy, done      : frame in progress / one-cycle completion pulse
//   timeout_err     : sticky, cleared by the next accepted start
//   result          : captured engine max sum
//   expected        : checker max sum (0 without checker)
//   mismatch        : checker disagreement (0 without checker)
//   eng             : engine link (master side)
//
// state | meaning
// IDLE  | host may write buffer; waits for start
// GAP   | one cycle of s_valid=0 so the engine drops its old s_valid_out
// SEND  | one sample per cycle, no bubbles
// WAIT  | watch for s_valid_out rising edge or timeout
// DONE  | done pulse, then back to IDLE
module subseq_frame_tx
  import subseq_frame_tx_pkg::*;
#(
  parameter int FRAME_LEN = ENG_FRAME_LEN,
  parameter int DW        = ENG_DW,
  parameter int SW        = ENG_SW,
  parameter int TIMEOUT   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [2:0]           wr_addr,
  input  logic signed [DW-1:0] wr_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [SW-1:0]        result,
  output logic [SW-1:0]        expected,
  output logic                 mismatch,
  subseq_frame_tx_if.master    eng
);

  localparam logic [2:0] S_IDLE = 3'(IDLE);
  localparam logic [2:0] S_GAP  = 3'(GAP);
  localparam logic [2:0] S_SEND = 3'(SEND);
  localparam logic [2:0] S_WAIT = 3'(WAIT);
  localparam logic [2:0] S_DONE = 3'(DONE);

  localparam int AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int IW = $clog2(FRAME_LEN + 1);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [2:0]           state;
  logic [IW-1:0]        idx;   // number of samples already placed on s_data
  logic [CW-1:0]        cnt;
  logic                 vo_prev;
  logic                 vo_rise;
  logic signed [DW-1:0] frame_buf [FRAME_LEN];

  assign vo_rise = eng.s_valid_out && !vo_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      cnt         <= '0;
      vo_prev     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      result      <= '0;
      eng.s_valid <= 1'b0;
      eng.s_data  <= '0;
      for (int i = 0; i < FRAME_LEN; i++) frame_buf[i] <= '0;
    end else begin
      vo_prev <= eng.s_valid_out;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          // A write in the start cycle still lands before the first read in GAP.
          if (wr_en) frame_buf[wr_addr] <= wr_data;
          if (start) begin
            state       <= S_GAP;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
            idx         <= '0;
          end
        end
        // GAP loads sample 0 so it appears in the first SEND cycle.
        S_GAP, S_SEND: begin
          if (idx == IDX_LAST) begin
            state       <= S_WAIT;
            eng.s_valid <= 1'b0;
            cnt         <= '0;
          end else begin
            state       <= S_SEND;
            eng.s_valid <= 1'b1;
            eng.s_data  <= frame_buf[idx[AW-1:0]];
            idx         <= idx + 1'b1;
          end
        end
        S_WAIT: begin
          if (vo_rise) begin
            result <= eng.s_max_sum;
            state  <= S_DONE;
            done   <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_DONE;
            done        <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state       <= S_IDLE;
          busy        <= 1'b0;
          eng.s_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SUBSEQ_TX_CHECK_EN
  logic          start_ok;
  logic          acc_en;
  logic [SW-1:0] acc_max;

  assign start_ok = (state == S_IDLE) && start;
  // Accumulate each sample as it is loaded onto s_data, so the full-frame
  // maximum is ready on the same edge that enters WAIT.
  assign acc_en   = ((state == S_GAP) || (state == S_SEND)) && (idx != IDX_LAST);

  subseq_ref_acc #(.DW(DW), .SW(SW)) u_ref_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_ok),
    .en      (acc_en),
    .din     (frame_buf[idx[AW-1:0]]),
    .max_out (acc_max)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected <= '0;
      mismatch <= 1'b0;
    end else begin
      if (start_ok) mismatch <= 1'b0;
      if ((state == S_SEND) && (idx == IDX_LAST)) expected <= acc_max;
      if ((state == S_WAIT) && vo_rise) mismatch <= (eng.s_max_sum != expected);
    end
  end
`else
  assign expected = '0;
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_subseq_frame_tx.sv
module tb_subseq_frame_tx;
  import subseq_frame_tx_pkg::*;

  localparam int FL  = ENG_FRAME_LEN;
  localparam int DW  = ENG_DW;
  localparam int SW  = ENG_SW;
  localparam int TMO = 32;
`ifdef SUBSEQ_TX_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 wr_en;
  logic [2:0]           wr_addr;
  logic signed [DW-1:0] wr_data;
  logic                 start;
  logic                 busy, done, timeout_err, mismatch;
  logic [SW-1:0]        result, expected;

  subseq_frame_tx_if eng_if ();

  subseq_frame_tx #(.FRAME_LEN(FL), .DW(DW), .SW(SW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .timeout_err(timeout_err),
    .result(result), .expected(expected), .mismatch(mismatch), .eng(eng_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic signed [DW-1:0] model_buf [FL];
  logic [SW-1:0]        last_result;

  // observations of the most recent frame (cycle 0 = start cycle)
  logic signed [DW-1:0] got[$];
  int first_v, last_v, n_v, done_cyc, n_done, resp_cyc;
  logic busy_c1, tmo_c1, mm_c1, busy_after, tmo_done, mm_done, hung;
  logic [SW-1:0] res_done, exp_done;

  // Best contiguous sum (empty subsequence allowed) by brute force.
  function automatic int best_sum();
    int best = 0;
    for (int i = 0; i < FL; i++) begin
      int s = 0;
      for (int j = i; j < FL; j++) begin
        s += int'(model_buf[j]);
        if (s > best) best = s;
      end
    end
    return best;
  endfunction

  function automatic logic [SW-1:0] exp_model();
    return CHK ? SW'(best_sum()) : '0;
  endfunction

  function automatic logic mm_model(input logic [SW-1:0] answer);
    return CHK && (answer != SW'(best_sum()));
  endfunction

  task automatic write_all();
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = model_buf[i];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Starts a frame and plays the engine: answers `val` `delay` cycles after the
  // last sample (or never). Optional stray start/write injections and a write
  // in the start cycle itself.
  task automatic run_frame(input bit respond, input int delay, input logic [SW-1:0] val,
                           input int inj_start, input int inj_wr,
                           input int wr0_addr, input logic signed [DW-1:0] wr0_data);
    got.delete();
    first_v = -1; last_v = -1; n_v = 0; done_cyc = -1; n_done = 0; resp_cyc = -1; hung = 1'b1;
    @(negedge clk);
    start = 1'b1;
    eng_if.s_valid_out = 1'b0;
    eng_if.s_max_sum = '0;
    if (wr0_addr >= 0) begin
      wr_en = 1'b1; wr_addr = 3'(wr0_addr); wr_data = wr0_data;
      model_buf[wr0_addr] = wr0_data;
    end
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      start   = (c == inj_start);
      wr_en   = (c == inj_wr);
      wr_addr = 3'd0;
      wr_data = ~model_buf[0];
      if (c == 1) begin busy_c1 = busy; tmo_c1 = timeout_err; mm_c1 = mismatch; end
      if (eng_if.s_valid) begin
        if (first_v < 0) first_v = c;
        last_v = c; n_v++;
        got.push_back(eng_if.s_data);
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = c; res_done = result; exp_done = expected;
          mm_done = mismatch; tmo_done = timeout_err;
        end
      end
      if (respond && last_v > 0 && resp_cyc < 0 && c == last_v + delay) begin
        eng_if.s_valid_out = 1'b1; eng_if.s_max_sum = val; resp_cyc = c;
      end
      if (done_cyc > 0 && c == done_cyc + 1) busy_after = busy;
      if (done_cyc > 0 && c == done_cyc + 2) begin hung = 1'b0; break; end
    end
    start = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    eng_if.s_valid_out = 1'b0; eng_if.s_max_sum = '0;
    for (int i = 0; i < FL; i++) model_buf[i] = '0;
    last_result = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, timeout_err, mismatch, eng_if.s_valid} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 00000", {busy, done, timeout_err, mismatch, eng_if.s_valid});
    end
    n_cmp++;
    if ({result, expected, eng_if.s_data} !== '0) begin
      n_bad++; $display("FAIL reset_values: result %0d expected %0d s_data %0d want all 0", result, expected, eng_if.s_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ascending();
    int errs = 0;
    for (int i = 0; i < FL; i++) model_buf[i] = DW'(i + 1);
    write_all();
    run_frame(1'b1, 11, 12'd36, -1, -1, -1, '0);
    n_cmp++; if (hung) begin n_bad++; $display("FAIL asc_hung: no done within budget"); end
    n_cmp++; if (first_v != 2) begin n_bad++; $display("FAIL asc_first_valid: got cycle %0d want 2", first_v); end
    n_cmp++; if (n_v != 8 || last_v != 9) begin n_bad++; $display("FAIL asc_burst: got %0d samples ending cycle %0d want 8 ending 9", n_v, last_v); end
    if (got.size() != FL) errs++;
    else for (int i = 0; i < FL; i++) if (got[i] !== model_buf[i]) errs++;
    n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL asc_samples: %0d wrong, got %0d samples want %0d", errs, got.size(), FL); end
    n_cmp++; if (done_cyc != 21) begin n_bad++; $display("FAIL asc_done_cycle: got %0d want 21", done_cyc); end
    n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL asc_done_pulses: got %0d want 1", n_done); end
    n_cmp++; if (res_done !== 12'd36) begin n_bad++; $display("FAIL asc_result: got %0d want 36", res_done); end
    n_cmp++; if (exp_done !== exp_model()) begin n_bad++; $display("FAIL asc_expected: got %0d want %0d", exp_done, exp_model()); end
    n_cmp++; if (mm_done !== mm_model(12'd36)) begin n_bad++; $display("FAIL asc_mismatch: got %b want %b", mm_done, mm_model(12'd36)); end
    n_cmp++; if (busy_c1 !== 1'b1) begin n_bad++; $display("FAIL asc_busy_gap: got %b want 1", busy_c1); end
    n_cmp++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL asc_busy_after: got %b want 0", busy_after); end
    last_result = 12'd36;
  endtask

  task automatic test_negative();
    for (int i = 0; i < FL; i++) model_buf[i] = DW'(-(i + 1));
    write_all();
    run_frame(1'b1, 11, 12'd0, -1, -1, -1, '0);
    n_cmp++; if (res_done !== 12'd0) begin n_bad++; $display("FAIL neg_result: got %0d want 0", res_done); end
    n_cmp++; if (exp_done !== exp_model()) begin n_bad++; $display("FAIL neg_expected: got %0d want %0d", exp_done, exp_model()); end
    n_cmp++; if (mm_done !== mm_model(12'd0)) begin n_bad++; $display("FAIL neg_mismatch: got %b want %b", mm_done, mm_model(12'd0)); end
    n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL neg_done_pulses: got %0d want 1", n_done); end
    last_result = 12'd0;
  endtask

  task automatic test_mixed();
    int mix [FL] = '{-2, 5, -1, 6, -20, 3, 4, -1};
    int errs = 0;
    for (int i = 0; i < FL; i++) model_buf[i] = DW'(mix[i]);
    write_all();
    run_frame(1'b1, 11, 12'd10, -1, -1, -1, '0);
    n_cmp++; if (res_done !== 12'd10) begin n_bad++; $display("FAIL mix_result: got %0d want 10", res_done); end
    n_cmp++; if (exp_done !== exp_model()) begin n_bad++; $display("FAIL mix_expected: got %0d want %0d", exp_done, exp_model()); end
    n_cmp++; if (mm_done !== mm_model(12'd10)) begin n_bad++; $display("FAIL mix_mismatch: got %b want %b", mm_done, mm_model(12'd10)); end
    run_frame(1'b1, 11, 12'd7, -1, -1, -1, '0);
    if (got.size() != FL) errs++;
    else for (int i = 0; i < FL; i++) if (got[i] !== model_buf[i]) errs++;
    n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL mix_rerun_samples: %0d wrong, got %0d samples", errs, got.size()); end
    n_cmp++; if (res_done !== 12'd7) begin n_bad++; $display("FAIL mix_bad_result: got %0d want 7", res_done); end
    n_cmp++; if (mm_done !== mm_model(12'd7)) begin n_bad++; $display("FAIL mix_bad_mismatch: got %b want %b", mm_done, mm_model(12'd7)); end
    last_result = 12'd7;
  endtask

  task automatic test_timeout();
    run_frame(1'b0, 0, '0, -1, -1, -1, '0);
    n_cmp++; if (hung) begin n_bad++; $display("FAIL tmo_hung: no done within budget"); end
    n_cmp++; if (mm_c1 !== 1'b0) begin n_bad++; $display("FAIL tmo_mm_cleared: got %b want 0", mm_c1); end
    n_cmp++; if (done_cyc != 10 + TMO) begin n_bad++; $display("FAIL tmo_done_cycle: got %0d want %0d", done_cyc, 10 + TMO); end
    n_cmp++; if (tmo_done !== 1'b1) begin n_bad++; $display("FAIL tmo_flag: got %b want 1", tmo_done); end
    n_cmp++; if (res_done !== last_result) begin n_bad++; $display("FAIL tmo_result_held: got %0d want %0d", res_done, last_result); end
    n_cmp++; if (mm_done !== 1'b0) begin n_bad++; $display("FAIL tmo_mismatch: got %b want 0", mm_done); end
    n_cmp++; if (exp_done !== exp_model()) begin n_bad++; $display("FAIL tmo_expected: got %0d want %0d", exp_done, exp_model()); end
    n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL tmo_done_pulses: got %0d want 1", n_done); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
    run_frame(1'b1, 4, SW'(best_sum()), -1, -1, -1, '0);
    n_cmp++; if (tmo_c1 !== 1'b0) begin n_bad++; $display("FAIL tmo_cleared_by_start: got %b want 0", tmo_c1); end
    n_cmp++; if (tmo_done !== 1'b0) begin n_bad++; $display("FAIL tmo_clean_frame: got %b want 0", tmo_done); end
    last_result = SW'(best_sum());
  endtask

  task automatic test_reset_mid_frame();
    logic sv_before;
    for (int i = 0; i < FL; i++) model_buf[i] = DW'($urandom_range(1, 100));
    write_all();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    sv_before = eng_if.s_valid;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (sv_before !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_send: got s_valid %b want 1", sv_before); end
    n_cmp++; if ({eng_if.s_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL rstmid_async: got s_valid/busy %b want 00", {eng_if.s_valid, busy}); end
    n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL rstmid_result: got %0d want 0", result); end
    #1 rst = 1'b0;
    for (int i = 0; i < FL; i++) model_buf[i] = '0;
    run_frame(1'b1, 5, 12'd0, -1, -1, -1, '0);
    begin
      int errs = 0;
      if (got.size() != FL) errs++;
      else for (int i = 0; i < FL; i++) if (got[i] !== '0) errs++;
      n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL rstmid_zero_frame: %0d nonzero/missing, got %0d samples", errs, got.size()); end
    end
    n_cmp++; if (res_done !== 12'd0) begin n_bad++; $display("FAIL rstmid_result2: got %0d want 0", res_done); end
    last_result = '0;
  endtask

  task automatic test_ignore();
    int errs = 0;
    logic stray = 1'b0;
    for (int i = 0; i < FL; i++) model_buf[i] = DW'($urandom_range(0, 255));
    write_all();
    run_frame(1'b1, 6, SW'(best_sum()), 5, 12, -1, '0);
    if (got.size() != FL) errs++;
    else for (int i = 0; i < FL; i++) if (got[i] !== model_buf[i]) errs++;
    n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL ign_samples: %0d wrong, got %0d samples", errs, got.size()); end
    n_cmp++; if (done_cyc != 16 || n_done != 1) begin n_bad++; $display("FAIL ign_done: got cycle %0d pulses %0d want 16 and 1", done_cyc, n_done); end
    repeat (4) begin
      @(negedge clk);
      stray = stray | eng_if.s_valid | busy;
    end
    n_cmp++; if (stray !== 1'b0) begin n_bad++; $display("FAIL ign_no_restart: got activity %b want 0", stray); end
    run_frame(1'b1, 3, SW'(best_sum()), -1, -1, -1, '0);
    n_cmp++; if (got.size() == 0 || got[0] !== model_buf[0]) begin n_bad++; $display("FAIL ign_buf_kept: got %0d want %0d", (got.size() == 0) ? 0 : int'(got[0]), int'(model_buf[0])); end
    last_result = SW'(best_sum());
  endtask

  task automatic test_start_with_write();
    int errs = 0;
    logic signed [DW-1:0] v = DW'($urandom_range(0, 255));
    run_frame(1'b1, 8, '0, -1, -1, 3, v);
    if (got.size() != FL) errs++;
    else for (int i = 0; i < FL; i++) if (got[i] !== model_buf[i]) errs++;
    n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL sw_samples: %0d wrong, got %0d samples", errs, got.size()); end
    n_cmp++; if (exp_done !== exp_model()) begin n_bad++; $display("FAIL sw_expected: got %0d want %0d", exp_done, exp_model()); end
    last_result = '0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int errs = 0;
      int d = int'($urandom_range(1, 20));
      logic [SW-1:0] ans;
      for (int i = 0; i < FL; i++) model_buf[i] = DW'($urandom_range(0, 255));
      write_all();
      ans = SW'(best_sum()) + SW'($urandom_range(0, 1));
      run_frame(1'b1, d, ans, -1, -1, -1, '0);
      if (got.size() != FL) errs++;
      else for (int i = 0; i < FL; i++) if (got[i] !== model_buf[i]) errs++;
      n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL rnd%0d_samples: %0d wrong, got %0d samples", k, errs, got.size()); end
      n_cmp++; if (done_cyc != 9 + d + 1 || n_done != 1) begin n_bad++; $display("FAIL rnd%0d_done: got cycle %0d pulses %0d want %0d and 1", k, done_cyc, n_done, 10 + d); end
      n_cmp++; if (res_done !== ans) begin n_bad++; $display("FAIL rnd%0d_result: got %0d want %0d", k, res_done, ans); end
      n_cmp++; if (exp_done !== exp_model()) begin n_bad++; $display("FAIL rnd%0d_expected: got %0d want %0d", k, exp_done, exp_model()); end
      n_cmp++; if (mm_done !== mm_model(ans)) begin n_bad++; $display("FAIL rnd%0d_mismatch: got %b want %b", k, mm_done, mm_model(ans)); end
      last_result = ans;
    end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_negative();
    test_mixed();
    test_timeout();
    test_reset_mid_frame();
    test_ignore();
    test_start_with_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
